// File: rtl/uart_cmd_dispatcher.sv
// UART command frame dispatcher.
// Collects 14-byte frames (0x55 .. 0xAA) from a byte stream, checks tail,
// CRC-8 (poly 0x07) and header fields, then issues either a channel
// configuration strobe (func 0x01) or a channel enable strobe (func 0x02).
// Partial frames are dropped after TIMEOUT_CYC idle cycles.
module uart_cmd_dispatcher #(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              cfg_valid,
    output logic [7:0]        cfg_ch,
    output logic [7:0]        cfg_duty,
    output logic [15:0]       cfg_pulse_dessert,
    output logic [7:0]        cfg_pulse_num,
    output logic [31:0]       cfg_pat,
    output logic              en_valid,
    output logic [7:0]        en_ch,
    output logic              en_state,
    output logic [NUM_CH-1:0] ch_enable,
    output logic              frame_ok,
    output logic              crc_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       SOF_BYTE = 8'h55;
    localparam logic [7:0]       EOF_BYTE = 8'hAA;
    localparam logic [7:0]       FUNC_CFG = 8'h01;
    localparam logic [7:0]       FUNC_EN  = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_DISPATCH
    } state_t;

    state_t            state_q;
    logic [3:0]        idx_q;
    logic [7:0]        crc_q;
    logic [7:0]        crc_d;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        frame_q [1:13];

    logic              cfg_valid_q;
    logic [7:0]        cfg_ch_q;
    logic [7:0]        cfg_duty_q;
    logic [15:0]       cfg_pulse_q;
    logic [7:0]        cfg_pulse_num_q;
    logic [31:0]       cfg_pat_q;
    logic              en_valid_q;
    logic [7:0]        en_ch_q;
    logic              en_state_q;
    logic [NUM_CH-1:0] ch_enable_q;
    logic              frame_ok_q;
    logic              crc_err_q;
    logic              frame_err_q;

    // One CRC-8 step over a whole byte, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign crc_d = crc8_byte(crc_q, rx_data);

    // Decoded header fields of the captured frame.
    logic [7:0] f_func;
    logic [7:0] f_ch;
    logic [7:0] f_ctrl;
    logic       ch_in_range;
    logic       func_known;
    logic       capture;

    assign f_func      = frame_q[1];
    assign f_ch        = frame_q[2];
    assign f_ctrl      = frame_q[3];
    assign ch_in_range = (f_ch != 8'd0) && (f_ch <= 8'(NUM_CH));
    assign func_known  = (f_func == FUNC_CFG) || (f_func == FUNC_EN);
    assign capture     = (state_q == ST_RECV) && rx_valid;

    // Frame byte buffer, written at the current index while receiving.
    // NOTE: the buffer has no reset; its contents are only read after a full
    // frame has overwritten every byte, and leaving it unreset keeps it plain RAM-like storage.
    always_ff @(posedge sys_clk) begin
        if (capture) begin
            frame_q[idx_q] <= rx_data;
        end
    end

    // Frame FSM with registered strobes, held configuration and enables.
    // NOTE: every state register here uses non-blocking assignment so all
    // updates take effect together at the clock edge, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            crc_q           <= '0;
            tmo_q           <= '0;
            cfg_valid_q     <= 1'b0;
            cfg_ch_q        <= '0;
            cfg_duty_q      <= '0;
            cfg_pulse_q     <= '0;
            cfg_pulse_num_q <= '0;
            cfg_pat_q       <= '0;
            en_valid_q      <= 1'b0;
            en_ch_q         <= '0;
            en_state_q      <= 1'b0;
            ch_enable_q     <= '0;
            frame_ok_q      <= 1'b0;
            crc_err_q       <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            cfg_valid_q <= 1'b0;
            en_valid_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SOF_BYTE) begin
                        state_q <= ST_RECV;
                        idx_q   <= 4'd1;
                        crc_q   <= '0;
                        tmo_q   <= '0;
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        tmo_q <= '0;
                        // CRC covers func..PAT3 (indices 1..11) only.
                        if (idx_q <= 4'd11) begin
                            crc_q <= crc_d;
                        end
                        if (idx_q == 4'd13) begin
                            state_q <= ST_CHECK;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Strobes are loaded here so they are visible during
                    // DISPATCH, two cycles after the tail byte.
                    if (frame_q[13] != EOF_BYTE) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (crc_q != frame_q[12]) begin
                        crc_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (!func_known || !ch_in_range) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        frame_ok_q <= 1'b1;
                        state_q    <= ST_DISPATCH;
                        if (f_func == FUNC_CFG) begin
                            cfg_valid_q     <= 1'b1;
                            cfg_ch_q        <= f_ch;
                            cfg_duty_q      <= frame_q[4];
                            cfg_pulse_q     <= {frame_q[5], frame_q[6]};
                            cfg_pulse_num_q <= frame_q[7];
                            cfg_pat_q       <= {frame_q[8], frame_q[9], frame_q[10], frame_q[11]};
                        end else begin
                            en_valid_q <= 1'b1;
                            en_ch_q    <= f_ch;
                            en_state_q <= f_ctrl[0];
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (f_ch == 8'(i + 1)) begin
                                    ch_enable_q[i] <= f_ctrl[0];
                                end
                            end
                        end
                    end
                end
                ST_DISPATCH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_valid         = cfg_valid_q;
    assign cfg_ch            = cfg_ch_q;
    assign cfg_duty          = cfg_duty_q;
    assign cfg_pulse_dessert = cfg_pulse_q;
    assign cfg_pulse_num     = cfg_pulse_num_q;
    assign cfg_pat           = cfg_pat_q;
    assign en_valid          = en_valid_q;
    assign en_ch             = en_ch_q;
    assign en_state          = en_state_q;
    assign ch_enable         = ch_enable_q;
    assign frame_ok          = frame_ok_q;
    assign crc_err           = crc_err_q;
    assign frame_err         = frame_err_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Self-checking bench for uart_cmd_dispatcher: a table of spec frames, a few
// hand-written multi-cycle sequences (timeout, reset mid-frame, bytes during
// CHECK/DISPATCH) and randomized frames against a frame-level reference model.
module tb_uart_cmd_dispatcher;

    localparam int NUM_CH      = 4;
    localparam int TIMEOUT_CYC = 40;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              cfg_valid;
    logic [7:0]        cfg_ch;
    logic [7:0]        cfg_duty;
    logic [15:0]       cfg_pulse_dessert;
    logic [7:0]        cfg_pulse_num;
    logic [31:0]       cfg_pat;
    logic              en_valid;
    logic [7:0]        en_ch;
    logic              en_state;
    logic [NUM_CH-1:0] ch_enable;
    logic              frame_ok;
    logic              crc_err;
    logic              frame_err;
    logic              busy;

    always #5 sys_clk = ~sys_clk;

    uart_cmd_dispatcher #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .cfg_valid         (cfg_valid),
        .cfg_ch            (cfg_ch),
        .cfg_duty          (cfg_duty),
        .cfg_pulse_dessert (cfg_pulse_dessert),
        .cfg_pulse_num     (cfg_pulse_num),
        .cfg_pat           (cfg_pat),
        .en_valid          (en_valid),
        .en_ch             (en_ch),
        .en_state          (en_state),
        .ch_enable         (ch_enable),
        .frame_ok          (frame_ok),
        .crc_err           (crc_err),
        .frame_err         (frame_err),
        .busy              (busy)
    );

    int checks     = 0;
    int failures   = 0;
    int strobe_cnt = 0;
    int excl_viol  = 0;

    typedef enum int {K_CFG, K_EN, K_CRC, K_FERR} kind_t;

    // crc_mode: 0 = use frame byte as written, 1 = correct CRC, 2 = corrupted CRC
    typedef struct {
        logic [111:0] frame;
        int           crc_mode;
        kind_t        kind;
        logic [3:0]   ch_en;
    } vec_t;

    vec_t vecs [14];

    // Reference model state (what the outputs should hold).
    logic [3:0]  m_ch_en;
    logic [7:0]  m_cfg_ch;
    logic [7:0]  m_cfg_duty;
    logic [15:0] m_cfg_pulse;
    logic [7:0]  m_cfg_num;
    logic [31:0] m_cfg_pat;
    logic [7:0]  m_en_ch;
    logic        m_en_state;

    // Count every strobe and any cycle with more than one result strobe.
    always @(negedge sys_clk) begin
        int n;
        n = int'(frame_ok) + int'(crc_err) + int'(frame_err);
        strobe_cnt += n;
        if (n > 1) excl_viol++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fb(input logic [111:0] f, input int i);
        return f[111 - 8*i -: 8];
    endfunction

    // Bit-serial CRC-8 over bytes 1..11 of the frame.
    function automatic logic [7:0] ref_crc(input logic [111:0] f);
        logic [7:0]  c;
        logic [87:0] msg;
        logic        fbk;
        c   = 8'h00;
        msg = f[103:16];
        for (int k = 87; k >= 0; k--) begin
            fbk = c[7] ^ msg[k];
            c   = {c[6:0], 1'b0} ^ (fbk ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [111:0] set_crc(input logic [111:0] f, input int mode);
        logic [111:0] r;
        r = f;
        if (mode == 1) r[15:8] = ref_crc(f);
        if (mode == 2) r[15:8] = ref_crc(f) ^ 8'hFF;
        return r;
    endfunction

    function automatic kind_t predict(input logic [111:0] f);
        logic [7:0] func;
        logic [7:0] ch;
        func = fb(f, 1);
        ch   = fb(f, 2);
        if (fb(f, 13) != 8'hAA) return K_FERR;
        if (ref_crc(f) != fb(f, 12)) return K_CRC;
        if (ch < 8'd1 || ch > 8'(NUM_CH)) return K_FERR;
        if (func == 8'h01) return K_CFG;
        if (func == 8'h02) return K_EN;
        return K_FERR;
    endfunction

    task automatic model_update(input logic [111:0] f, input kind_t k);
        int ch;
        ch = int'(fb(f, 2));
        if (k == K_CFG) begin
            m_cfg_ch    = fb(f, 2);
            m_cfg_duty  = fb(f, 4);
            m_cfg_pulse = {fb(f, 5), fb(f, 6)};
            m_cfg_num   = fb(f, 7);
            m_cfg_pat   = {fb(f, 8), fb(f, 9), fb(f, 10), fb(f, 11)};
        end else if (k == K_EN) begin
            m_en_ch            = fb(f, 2);
            m_en_state         = fb(f, 3) & 8'h01;
            m_ch_en[ch - 1]    = m_en_state;
        end
    endtask

    task automatic model_reset();
        m_ch_en     = '0;
        m_cfg_ch    = '0;
        m_cfg_duty  = '0;
        m_cfg_pulse = '0;
        m_cfg_num   = '0;
        m_cfg_pat   = '0;
        m_en_ch     = '0;
        m_en_state  = 1'b0;
    endtask

    function automatic logic [4:0] strobes_for(input kind_t k);
        case (k)
            K_CFG:   return 5'b10100;
            K_EN:    return 5'b01100;
            K_CRC:   return 5'b00010;
            default: return 5'b00001;
        endcase
    endfunction

    function automatic logic [4:0] strobes();
        return {cfg_valid, en_valid, frame_ok, crc_err, frame_err};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_fields();
        check("cfg_fields", 64'({cfg_ch, cfg_duty, cfg_pulse_dessert, cfg_pulse_num}),
              64'({m_cfg_ch, m_cfg_duty, m_cfg_pulse, m_cfg_num}));
        check("cfg_pat", 64'(cfg_pat), 64'(m_cfg_pat));
        check("en_fields", 64'({en_ch, en_state}), 64'({m_en_ch, m_en_state}));
        check("ch_enable", 64'(ch_enable), 64'(m_ch_en));
    endtask

    // Send one frame, then verify strobe timing and held outputs.
    task automatic run_frame(input logic [111:0] f, input kind_t k, input int gap_max);
        for (int i = 0; i < 14; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            send_byte(fb(f, i));
            if (i == 6) check("busy_recv", 64'(busy), 64'd1);
        end
        check("strobe_early", 64'(strobes()), 64'd0);
        tick();
        model_update(f, k);
        check("strobe", 64'(strobes()), 64'(strobes_for(k)));
        check_fields();
        tick();
        check("strobe_clear_idle", 64'({strobes(), busy}), 64'd0);
    endtask

    initial begin
        logic [111:0] f;
        int           k_to;
        int           s0;

        vecs[0]  = '{112'h55_02_01_01_00_00_00_00_00_00_00_00_2F_AA, 0, K_EN,   4'b0001};
        vecs[1]  = '{112'h55_02_01_01_00_00_00_00_00_00_00_00_30_AA, 0, K_CRC,  4'b0001};
        vecs[2]  = '{112'h55_02_01_01_00_00_00_00_00_00_00_00_2F_AB, 0, K_FERR, 4'b0001};
        vecs[3]  = '{112'h55_02_05_01_00_00_00_00_00_00_00_00_00_AA, 1, K_FERR, 4'b0001};
        vecs[4]  = '{112'h55_01_03_00_7F_12_34_09_DE_AD_BE_EF_00_AA, 1, K_CFG,  4'b0001};
        vecs[5]  = '{112'h55_03_01_01_00_00_00_00_00_00_00_00_00_AA, 1, K_FERR, 4'b0001};
        vecs[6]  = '{112'h55_02_00_01_00_00_00_00_00_00_00_00_00_AA, 1, K_FERR, 4'b0001};
        vecs[7]  = '{112'h55_02_04_01_00_00_00_00_00_00_00_00_00_AA, 1, K_EN,   4'b1001};
        vecs[8]  = '{112'h55_02_01_00_00_00_00_00_00_00_00_00_00_AA, 1, K_EN,   4'b1000};
        vecs[9]  = '{112'h55_02_02_01_00_00_00_00_00_00_00_00_00_AB, 2, K_FERR, 4'b1000};
        vecs[10] = '{112'h55_07_01_01_00_00_00_00_00_00_00_00_00_AA, 2, K_CRC,  4'b1000};
        vecs[11] = '{112'h55_01_02_55_55_55_55_55_55_55_55_55_00_AA, 1, K_CFG,  4'b1000};
        vecs[12] = '{112'h55_02_04_FE_00_00_00_00_00_00_00_00_00_AA, 1, K_EN,   4'b0000};
        vecs[13] = '{112'h55_02_02_03_00_00_00_00_00_00_00_00_00_AA, 1, K_EN,   4'b0010};

        // Reset: hold 5 cycles, everything low.
        sys_rst  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        idle(5);
        check("reset_out_a", 64'({cfg_valid, cfg_ch, cfg_duty, cfg_pulse_dessert, cfg_pulse_num}), 64'd0);
        check("reset_out_b", 64'({cfg_pat, en_valid, en_ch, en_state, ch_enable,
                                  frame_ok, crc_err, frame_err, busy}), 64'd0);
        sys_rst = 1'b0;
        idle(2);

        // Table-driven frames.
        for (int i = 0; i < 14; i++) begin
            f = set_crc(vecs[i].frame, vecs[i].crc_mode);
            run_frame(f, vecs[i].kind, 0);
            check($sformatf("vec%0d_ch_enable", i), 64'(ch_enable), 64'(vecs[i].ch_en));
        end

        // Junk bytes in IDLE are discarded, following frame is accepted.
        send_byte(8'h00);
        send_byte(8'h13);
        run_frame(set_crc(112'h55_02_03_01_00_00_00_00_00_00_00_00_00_AA, 1), K_EN, 0);
        check("junk_ch_enable", 64'(ch_enable), 64'(4'b0110));

        // Bytes arriving during CHECK and DISPATCH are dropped.
        f = set_crc(112'h55_01_04_00_40_00_10_05_11_22_33_44_00_AA, 1);
        for (int i = 0; i < 14; i++) send_byte(fb(f, i));
        send_byte(8'h55);
        model_update(f, K_CFG);
        check("drop_strobe", 64'(strobes()), 64'(5'b10100));
        send_byte(8'h55);
        check("drop_busy", 64'(busy), 64'd0);
        run_frame(set_crc(112'h55_02_01_01_00_00_00_00_00_00_00_00_00_AA, 1), K_EN, 2);
        check("drop_ch_enable", 64'(ch_enable), 64'(4'b0111));

        // Timeout on a partial frame.
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h01);
        k_to = -1;
        for (int k = 1; k <= TIMEOUT_CYC + 10; k++) begin
            tick();
            if (frame_err === 1'b1) begin
                k_to = k;
                break;
            end
        end
        check("timeout_cycles", 64'(k_to), 64'(TIMEOUT_CYC));
        check("timeout_busy", 64'(busy), 64'd0);
        run_frame(set_crc(112'h55_02_02_00_00_00_00_00_00_00_00_00_00_AA, 1), K_EN, 0);
        check("timeout_ch_enable", 64'(ch_enable), 64'(4'b0101));

        // Reset after byte 7 discards the frame silently.
        s0 = strobe_cnt;
        f  = vecs[0].frame;
        for (int i = 0; i < 7; i++) send_byte(fb(f, i));
        sys_rst = 1'b1;
        idle(2);
        sys_rst = 1'b0;
        idle(1);
        model_reset();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ch_enable", 64'(ch_enable), 64'd0);
        check("rst_mid_no_strobe", 64'(strobe_cnt), 64'(s0));
        run_frame(vecs[0].frame, K_EN, 0);
        check("rst_mid_ch_enable_after", 64'(ch_enable), 64'(4'b0001));

        // Randomized frames against the reference model.
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [7:0] junk;
            f = '0;
            f[111:104] = 8'h55;
            for (int i = 1; i <= 11; i++) f[111 - 8*i -: 8] = 8'($urandom);
            r = int'($urandom_range(0, 9));
            f[103:96] = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
            f[95:88]  = 8'($urandom_range(0, 6));
            f = set_crc(f, ($urandom_range(0, 7) == 0) ? 2 : 1);
            f[7:0] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 169)) : 8'hAA;
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h55) junk = 8'h00;
                send_byte(junk);
            end
            run_frame(f, predict(f), 3);
        end

        check("exclusive_strobes", 64'(excl_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
